// File: rtl/gpio_lite_reg_pkg.sv
// gpio_lite_reg_pkg: register offsets, register enum and decode helpers for gpio_lite.
package gpio_lite_reg_pkg;
   localparam logic [31:0] GPIO_LITE_INTR_STATE_OFFSET      = 32'h00;
   localparam logic [31:0] GPIO_LITE_INTR_ENABLE_OFFSET     = 32'h04;
   localparam logic [31:0] GPIO_LITE_INTR_TEST_OFFSET       = 32'h08;
   localparam logic [31:0] GPIO_LITE_DATA_IN_OFFSET         = 32'h10;
   localparam logic [31:0] GPIO_LITE_DIRECT_OUT_OFFSET      = 32'h14;
   localparam logic [31:0] GPIO_LITE_MASKED_OUT_LOWER_OFFSET = 32'h18;
   localparam logic [31:0] GPIO_LITE_MASKED_OUT_UPPER_OFFSET = 32'h1C;
   localparam logic [31:0] GPIO_LITE_DIRECT_OE_OFFSET       = 32'h20;
   localparam logic [31:0] GPIO_LITE_MASKED_OE_LOWER_OFFSET = 32'h24;
   localparam logic [31:0] GPIO_LITE_MASKED_OE_UPPER_OFFSET = 32'h28;
   localparam logic [31:0] GPIO_LITE_INTR_CTRL_EN_RISING_OFFSET  = 32'h2C;
   localparam logic [31:0] GPIO_LITE_INTR_CTRL_EN_FALLING_OFFSET = 32'h30;
   localparam logic [31:0] GPIO_LITE_INTR_CTRL_EN_LVLHIGH_OFFSET = 32'h34;
   localparam logic [31:0] GPIO_LITE_INTR_CTRL_EN_LVLLOW_OFFSET  = 32'h38;
   localparam int NumRegs = 14;
   typedef enum logic [3:0] {
      RegIntrState, RegIntrEnable, RegIntrTest, RegDataIn, RegDirectOut,
      RegMaskedOutLower, RegMaskedOutUpper, RegDirectOe, RegMaskedOeLower,
      RegMaskedOeUpper, RegCtrlRise, RegCtrlFall, RegCtrlLvlHigh, RegCtrlLvlLow,
      RegNone
   } gpio_reg_e;
   function automatic gpio_reg_e decode_reg(logic [31:0] off);
      case (off)
         GPIO_LITE_INTR_STATE_OFFSET:          return RegIntrState;
         GPIO_LITE_INTR_ENABLE_OFFSET:         return RegIntrEnable;
         GPIO_LITE_INTR_TEST_OFFSET:           return RegIntrTest;
         GPIO_LITE_DATA_IN_OFFSET:             return RegDataIn;
         GPIO_LITE_DIRECT_OUT_OFFSET:          return RegDirectOut;
         GPIO_LITE_MASKED_OUT_LOWER_OFFSET:    return RegMaskedOutLower;
         GPIO_LITE_MASKED_OUT_UPPER_OFFSET:    return RegMaskedOutUpper;
         GPIO_LITE_DIRECT_OE_OFFSET:           return RegDirectOe;
         GPIO_LITE_MASKED_OE_LOWER_OFFSET:     return RegMaskedOeLower;
         GPIO_LITE_MASKED_OE_UPPER_OFFSET:     return RegMaskedOeUpper;
         GPIO_LITE_INTR_CTRL_EN_RISING_OFFSET:  return RegCtrlRise;
         GPIO_LITE_INTR_CTRL_EN_FALLING_OFFSET: return RegCtrlFall;
         GPIO_LITE_INTR_CTRL_EN_LVLHIGH_OFFSET: return RegCtrlLvlHigh;
         GPIO_LITE_INTR_CTRL_EN_LVLLOW_OFFSET:  return RegCtrlLvlLow;
         default:                              return RegNone;
      endcase
   endfunction
   // Upper 16 bits of the write data select which bits of the half take the lower 16.
   function automatic logic [15:0] masked_upd(logic [15:0] cur, logic [31:0] wd);
      return (cur & ~wd[31:16]) | (wd[15:0] & wd[31:16]);
   endfunction
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel types and opcodes shared by TL-UL devices.
package tlul_pkg;
   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;
   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;
   localparam logic [7:0] TL_D_USER_DEFAULT = 8'h00;
   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [7:0]  a_user;
      logic        d_ready;
   } tl_h2d_t;
   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [7:0]  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

// File: rtl/gpio_lite_tl_adapter.sv
// gpio_lite_tl_adapter: single-outstanding TL-UL device port with error checks and a registered response.
module gpio_lite_tl_adapter
   import tlul_pkg::*;
   import gpio_lite_reg_pkg::*;
#(
   parameter int AddrLsbW = 6
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  tl_h2d_t             tl_i,
   output tl_d2h_t             tl_o,
   output logic                reg_we_o,
   output logic                reg_re_o,
   output logic [AddrLsbW-1:0] reg_addr_o,
   output logic [31:0]         reg_wdata_o,
   input  logic [31:0]         reg_rdata_i
);
   tl_d2h_t rsp_q;
   logic acc, is_get, is_put, err;
   logic unused_tl;
   assign unused_tl = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[31:AddrLsbW]};
   always_comb begin
      acc    = tl_i.a_valid & ~rsp_q.d_valid;
      is_get = tl_i.a_opcode == Get;
      is_put = tl_i.a_opcode == PutFullData || tl_i.a_opcode == PutPartialData;
      err    = ~(is_get | is_put) | (tl_i.a_address[1:0] != 2'b00) | (tl_i.a_size != 2'd2)
             | (is_put & (tl_i.a_mask != 4'hf))
             | (decode_reg(32'(tl_i.a_address[AddrLsbW-1:0])) == RegNone);
      reg_we_o    = acc & is_put & ~err;
      reg_re_o    = acc & is_get & ~err;
      reg_addr_o  = tl_i.a_address[AddrLsbW-1:0];
      reg_wdata_o = tl_i.a_data;
      tl_o         = rsp_q;
      tl_o.a_ready = ~rsp_q.d_valid;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rsp_q <= '0;
      else if (acc) rsp_q <= '{
         d_valid:  1'b1,
         d_opcode: is_get ? AccessAckData : AccessAck,
         d_param:  3'd0,
         d_size:   tl_i.a_size,
         d_source: tl_i.a_source,
         d_sink:   1'b0,
         d_data:   reg_re_o ? reg_rdata_i : 32'h0,
         d_user:   TL_D_USER_DEFAULT,
         d_error:  err,
         a_ready:  1'b0
      };
      else if (tl_i.d_ready) rsp_q.d_valid <= 1'b0;
   end
endmodule

// File: rtl/gpio_lite.sv
// gpio_lite: 32-bit GPIO with masked output/enable writes and per-pin edge/level interrupts.
module gpio_lite
   import tlul_pkg::*;
   import gpio_lite_reg_pkg::*;
#(
   parameter int AddrLsbW = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  tl_h2d_t     tl_i,
   output tl_d2h_t     tl_o,
   input  logic [31:0] cio_gpio_i,
   output logic [31:0] cio_gpio_o,
   output logic [31:0] cio_gpio_en_o,
   output logic [31:0] intr_gpio_o
);
   logic                reg_we, reg_re;
   logic [AddrLsbW-1:0] reg_addr;
   logic [31:0]         reg_wdata, reg_rdata;
   gpio_reg_e           reg_sel;
   logic [NumRegs-1:0]  wr;
   logic [31:0] intr_state_q, intr_state_d, intr_en_q, intr_en_d, out_q, out_d, oe_q, oe_d;
   logic [31:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d, lvlh_en_q, lvlh_en_d, lvll_en_q, lvll_en_d;
   logic [31:0] meta_q, din_q, din_prev_q, set;
   logic        unused_re;
   assign unused_re = reg_re;
   gpio_lite_tl_adapter #(.AddrLsbW(AddrLsbW)) u_tl (
      .clk_i(clk_i), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
      .reg_we_o(reg_we), .reg_re_o(reg_re), .reg_addr_o(reg_addr),
      .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata)
   );
   assign reg_sel = decode_reg(32'(reg_addr));
   always_comb for (int i = 0; i < NumRegs; i++) wr[i] = reg_we && (int'(reg_sel) == i);
   always_comb begin
      set = (din_q & ~din_prev_q & rise_en_q) | (~din_q & din_prev_q & fall_en_q)
          | (din_q & lvlh_en_q) | (~din_q & lvll_en_q) | (wr[RegIntrTest] ? reg_wdata : 32'h0);
      // Set is OR-ed after the W1C so a concurrent event is never lost.
      intr_state_d = (intr_state_q & ~(wr[RegIntrState] ? reg_wdata : 32'h0)) | set;
      intr_en_d = wr[RegIntrEnable] ? reg_wdata : intr_en_q;
      rise_en_d = wr[RegCtrlRise] ? reg_wdata : rise_en_q;
      fall_en_d = wr[RegCtrlFall] ? reg_wdata : fall_en_q;
      lvlh_en_d = wr[RegCtrlLvlHigh] ? reg_wdata : lvlh_en_q;
      lvll_en_d = wr[RegCtrlLvlLow] ? reg_wdata : lvll_en_q;
      out_d = wr[RegDirectOut] ? reg_wdata :
         {wr[RegMaskedOutUpper] ? masked_upd(out_q[31:16], reg_wdata) : out_q[31:16],
          wr[RegMaskedOutLower] ? masked_upd(out_q[15:0], reg_wdata) : out_q[15:0]};
      oe_d = wr[RegDirectOe] ? reg_wdata :
         {wr[RegMaskedOeUpper] ? masked_upd(oe_q[31:16], reg_wdata) : oe_q[31:16],
          wr[RegMaskedOeLower] ? masked_upd(oe_q[15:0], reg_wdata) : oe_q[15:0]};
   end
   always_comb begin
      case (reg_sel)
         RegIntrState:      reg_rdata = intr_state_q;
         RegIntrEnable:     reg_rdata = intr_en_q;
         RegDataIn:         reg_rdata = din_q;
         RegDirectOut:      reg_rdata = out_q;
         RegMaskedOutLower: reg_rdata = {16'h0, out_q[15:0]};
         RegMaskedOutUpper: reg_rdata = {16'h0, out_q[31:16]};
         RegDirectOe:       reg_rdata = oe_q;
         RegMaskedOeLower:  reg_rdata = {16'h0, oe_q[15:0]};
         RegMaskedOeUpper:  reg_rdata = {16'h0, oe_q[31:16]};
         RegCtrlRise:       reg_rdata = rise_en_q;
         RegCtrlFall:       reg_rdata = fall_en_q;
         RegCtrlLvlHigh:    reg_rdata = lvlh_en_q;
         RegCtrlLvlLow:     reg_rdata = lvll_en_q;
         default:           reg_rdata = 32'h0;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         {meta_q, din_q, din_prev_q} <= '0;
         {intr_state_q, intr_en_q, out_q, oe_q} <= '0;
         {rise_en_q, fall_en_q, lvlh_en_q, lvll_en_q} <= '0;
      end else begin
         {meta_q, din_q, din_prev_q} <= {cio_gpio_i, meta_q, din_q};
         {intr_state_q, intr_en_q, out_q, oe_q} <= {intr_state_d, intr_en_d, out_d, oe_d};
         {rise_en_q, fall_en_q, lvlh_en_q, lvll_en_q} <= {rise_en_d, fall_en_d, lvlh_en_d, lvll_en_d};
      end
   end
   assign cio_gpio_o    = out_q;
   assign cio_gpio_en_o = oe_q;
   assign intr_gpio_o   = intr_state_q & intr_en_q;
endmodule

// File: tb/tb_gpio_lite.sv
// tb_gpio_lite: directed register, interrupt, error and reset checks for gpio_lite.
module tb_gpio_lite;
   import tlul_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   tl_h2d_t     tl_i;
   tl_d2h_t     tl_o;
   logic [31:0] gpio_i, gpio_o, gpio_en, intr;
   int          checks = 0, errors = 0;
   logic [7:0]  src = 8'h0;
   logic [31:0] r_data;
   logic        r_err;
   tl_d_op_e    r_op;

   gpio_lite dut (
      .clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o), .cio_gpio_i(gpio_i),
      .cio_gpio_o(gpio_o), .cio_gpio_en_o(gpio_en), .intr_gpio_o(intr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input tl_a_op_e op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [1:0] size);
      int n = 0;
      @(negedge clk);
      while (tl_o.d_valid && n < 4) begin @(negedge clk); n++; end
      src = src + 8'd1;
      tl_i = '0;
      tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = addr; tl_i.a_data = data;
      tl_i.a_mask = mask; tl_i.a_size = size; tl_i.a_source = src; tl_i.d_ready = 1'b1;
      @(posedge clk); #1;
      tl_i.a_valid = 1'b0;
      n = 0;
      while (!tl_o.d_valid && n < 4) begin @(posedge clk); #1; n++; end
      chk("rsp_latency", 32'(n), 32'd0);
      chk("rsp_source", 32'(tl_o.d_source), 32'(src));
      chk("rsp_size", 32'(tl_o.d_size), 32'(size));
      r_data = tl_o.d_data; r_err = tl_o.d_error; r_op = tl_o.d_opcode;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      xfer(Get, addr, 32'h0, 4'hf, 2'd2);
      chk({tag, "_data"}, r_data, exp);
      chk({tag, "_err"}, 32'(r_err), 32'd0);
      chk({tag, "_op"}, 32'(r_op), 32'(AccessAckData));
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
      xfer(PutFullData, addr, data, 4'hf, 2'd2);
      chk({tag, "_err"}, 32'(r_err), 32'd0);
      chk({tag, "_op"}, 32'(r_op), 32'(AccessAck));
   endtask

   task automatic bad(input tl_a_op_e op, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [1:0] size, input string tag);
      xfer(op, addr, 32'h1234_5678, mask, size);
      chk({tag, "_err"}, 32'(r_err), 32'd1);
      chk({tag, "_data"}, r_data, 32'h0);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tl_i = '0;
      gpio_i = 32'h0;
      wait_cycles(2);
      chk("rst_gpio_o", gpio_o, 32'h0);
      chk("rst_gpio_en", gpio_en, 32'h0);
      chk("rst_intr", intr, 32'h0);
      chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
      chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
      @(negedge clk); rst = 1'b0;

      rd(32'h14, 32'h0, "rd_out0");
      rd(32'h20, 32'h0, "rd_oe0");
      chk("out0", gpio_o, 32'h0);
      chk("oe0", gpio_en, 32'h0);

      wr(32'h14, 32'hFFFF_FFFF, "wr_out_ff");
      chk("out_ff", gpio_o, 32'hFFFF_FFFF);

      wr(32'h14, 32'h0, "wr_out_0");
      wr(32'h1C, 32'h00FF_00A5, "wr_mou");
      chk("out_mou", gpio_o, 32'h00A5_0000);
      rd(32'h1C, 32'h0000_00A5, "rd_mou");
      wr(32'h18, 32'h000F_0003, "wr_mol");
      chk("out_mol", gpio_o, 32'h00A5_0003);
      rd(32'h18, 32'h0000_0003, "rd_mol");
      rd(32'h14, 32'h00A5_0003, "rd_out_m");

      wr(32'h24, 32'hFFFF_1234, "wr_moel");
      chk("oe_moel", gpio_en, 32'h0000_1234);
      wr(32'h20, 32'hF0F0_F0F0, "wr_oe");
      wr(32'h28, 32'h0F00_0A00, "wr_moeu");
      chk("oe_moeu", gpio_en, 32'hFAF0_F0F0);
      rd(32'h28, 32'h0000_FAF0, "rd_moeu");

      wr(32'h2C, 32'h1, "wr_rise");
      wr(32'h04, 32'h1, "wr_ie0");
      @(negedge clk); gpio_i[0] = 1'b1;
      for (int i = 0; i < 3 && intr[0] !== 1'b1; i++) begin @(posedge clk); #1; end
      chk("intr_rise", intr, 32'h1);
      rd(32'h10, 32'h1, "rd_din");
      wr(32'h00, 32'h1, "w1c_rise");
      chk("intr_rise_clr", intr, 32'h0);
      @(negedge clk); gpio_i[0] = 1'b0;
      wait_cycles(4);
      chk("intr_no_fall", intr, 32'h0);

      wr(32'h34, 32'h10, "wr_lvlh");
      wr(32'h04, 32'h10, "wr_ie4");
      @(negedge clk); gpio_i[4] = 1'b1;
      wait_cycles(4);
      chk("intr_lvl", intr, 32'h10);
      wr(32'h00, 32'h10, "w1c_lvl_held");
      chk("intr_lvl_setwins", intr, 32'h10);
      @(negedge clk); gpio_i[4] = 1'b0;
      wait_cycles(4);
      wr(32'h00, 32'h10, "w1c_lvl");
      chk("intr_lvl_clr", intr, 32'h0);
      wr(32'h34, 32'h0, "wr_lvlh0");

      wr(32'h04, 32'h8000_0000, "wr_ie31");
      wr(32'h08, 32'h8000_0000, "wr_test");
      chk("intr_test", intr, 32'h8000_0000);
      rd(32'h08, 32'h0, "rd_test");
      rd(32'h00, 32'h8000_0000, "rd_state");

      bad(PutFullData, 32'h0C, 4'hf, 2'd2, "err_0c");
      chk("err_0c_op", 32'(r_op), 32'(AccessAck));
      bad(PutPartialData, 32'h14, 4'h3, 2'd2, "err_mask");
      rd(32'h14, 32'h00A5_0003, "rd_out_kept");
      bad(Get, 32'h15, 4'hf, 2'd2, "err_unal");
      bad(Get, 32'h14, 4'hf, 2'd1, "err_size");
      bad(tl_a_op_e'(3'h7), 32'h14, 4'hf, 2'd2, "err_op");
      bad(Get, 32'h3C, 4'hf, 2'd2, "err_3c");
      rd(32'h38, 32'h0, "rd_lvll");

      @(negedge clk);
      src = src + 8'd1;
      tl_i = '0;
      tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_address = 32'h14;
      tl_i.a_mask = 4'hf; tl_i.a_size = 2'd2; tl_i.a_source = src; tl_i.d_ready = 1'b0;
      @(posedge clk); #1;
      tl_i.a_valid = 1'b0;
      chk("pend_d_valid", 32'(tl_o.d_valid), 32'd1);
      @(negedge clk);
      chk("pend_hold", 32'(tl_o.d_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_d_valid", 32'(tl_o.d_valid), 32'd0);
      chk("abort_a_ready", 32'(tl_o.a_ready), 32'd1);
      chk("abort_gpio_o", gpio_o, 32'h0);
      chk("abort_gpio_en", gpio_en, 32'h0);
      chk("abort_intr", intr, 32'h0);
      wait_cycles(2);
      @(negedge clk); rst = 1'b0;
      rd(32'h14, 32'h0, "rd_out_post");
      rd(32'h04, 32'h0, "rd_ie_post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gpio_lite.md
Name: gpio_lite

Overview:
- 32-bit general-purpose I/O peripheral with a TL-UL device port, sitting on the peripheral crossbar at tl_periph_pkg::ADDR_SPACE_GPIO.
- Software drives output values and output enables, reads synchronized input values, and configures per-pin edge- and level-triggered interrupts.
- Command integrity is not checked here; no alerts are produced.

Parameters:
- AddrLsbW, 6, number of low address bits decoded; upper bits are ignored because the crossbar has already selected the block.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- tl_i  input  tlul_pkg::tl_h2d_t  TL-UL request channel
- tl_o  output  tlul_pkg::tl_d2h_t  TL-UL response channel
- cio_gpio_i  input  32  pad input values (asynchronous)
- cio_gpio_o  output  32  pad output values
- cio_gpio_en_o  output  32  pad output enables
- intr_gpio_o  output  32  per-pin interrupt, intr_state & intr_enable

Behaviour:
- Register map (byte offsets, all 32-bit):
  - 0x00 INTR_STATE, RW1C
  - 0x04 INTR_ENABLE, RW
  - 0x08 INTR_TEST, WO: writing 1 sets the INTR_STATE bit; reads return 0
  - 0x10 DATA_IN, RO, synchronized input
  - 0x14 DIRECT_OUT, RW
  - 0x18 MASKED_OUT_LOWER: [31:16] mask, [15:0] data; updates out[15:0] where mask=1
  - 0x1C MASKED_OUT_UPPER: same scheme, acting on out[31:16]
  - 0x20 DIRECT_OE, RW
  - 0x24 MASKED_OE_LOWER and 0x28 MASKED_OE_UPPER: same masked scheme, acting on oe
  - 0x2C INTR_CTRL_EN_RISING, 0x30 INTR_CTRL_EN_FALLING, 0x34 INTR_CTRL_EN_LVLHIGH, 0x38 INTR_CTRL_EN_LVLLOW, all RW
- Reads of the MASKED_* registers return {16'h0, corresponding data half}.
- Reset values: every register is 0.
  - Outputs during and right after reset: cio_gpio_o=0, cio_gpio_en_o=0, intr_gpio_o=0, tl_o.d_valid=0, tl_o.a_ready=1.
- TL-UL handshake:
  - One outstanding transaction.
  - a_ready = ~d_valid.
  - A request is accepted when a_valid && a_ready.
  - The response is registered: d_valid is asserted the cycle after acceptance and held until d_ready.
  - A write's register effect is visible on the outputs in that same response cycle.
- Response fields:
  - d_opcode: AccessAckData for Get, AccessAck for PutFullData/PutPartialData.
  - d_source and d_size are echoed from the request.
  - d_param=0, d_sink=0, d_user=tlul_pkg default.
- Errors set d_error=1, leave registers unchanged, and return d_data=0. Error cases:
  - unmapped offset, including 0x0C and offsets above 0x38
  - a_address[1:0] != 0
  - a_size != 2
  - a write with a_mask != 4'hf
  - an unsupported opcode
  - A read of any legal offset, including INTR_TEST, is never an error.
- Input path:
  - cio_gpio_i goes through a 2-flop synchronizer, giving data_in.
  - A third flop holds data_in_q, the previous value.
  - rise = data_in & ~data_in_q; fall = ~data_in & data_in_q.
- Interrupt set events, per bit:
  - (rise & EN_RISING)
  - | (fall & EN_FALLING)
  - | (data_in & EN_LVLHIGH)
  - | (~data_in & EN_LVLLOW)
  - | INTR_TEST write data
- Simultaneous set and W1C in the same cycle: set wins.
- Level interrupts re-set INTR_STATE every cycle while the level condition holds.
- Reset asserted mid-transaction aborts the transaction: the response is dropped and all state returns to reset values.

Decomposition:
- Shared package gpio_lite_reg_pkg holds the offset localparams (GPIO_LITE_*_OFFSET) and the register-address enum used by the decoder.
- TL-UL types and opcodes come from tlul_pkg.
- One sub-module, gpio_lite_tl_adapter, handles the TL-UL handshake, error checks and response register. It presents a reg_we/reg_re/reg_addr/reg_wdata/reg_rdata interface to the register core.

Test Plan:
- Reset, then read DIRECT_OUT and DIRECT_OE -> both return 0, d_error=0; cio_gpio_o=0, cio_gpio_en_o=0.
- PutFullData to 0x14 with data 0xFFFF_FFFF, mask 0xF -> d_valid next cycle, AccessAck, d_error=0, cio_gpio_o=0xFFFF_FFFF.
- DIRECT_OUT=0, then write MASKED_OUT_UPPER=0x00FF_00A5 -> cio_gpio_o=0x00A5_0000; a readback of 0x1C returns 0x0000_00A5.
- EN_RISING=0x1, INTR_ENABLE=0x1, drive cio_gpio_i[0] 0->1 -> intr_gpio_o[0]=1 within 3 cycles; write INTR_STATE=0x1 -> intr_gpio_o=0.
- INTR_ENABLE=0x8000_0000, write INTR_TEST=0x8000_0000 -> intr_gpio_o=0x8000_0000; a read of 0x08 returns 0.
- Write to 0x0C, then a write with mask 0x3 to 0x14 -> both d_error=1 and DIRECT_OUT is unchanged. Assert rst_i during a pending response -> d_valid drops immediately and all outputs return to 0.
